dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Word-organised data memory that serves the single-cycle/multi-cycle core's load/store requests through a req/ready handshake, with a programmable number of wait states.
- Core is the initiator; this block is the responder.
- Replaces the zero-latency data memory so the core's stall logic can be exercised.
- Array is named memory, so benches can preload and display words hierarchically.

Parameters:
- DEPTH_LOG2, 8, log2 of word count (256 words, byte addresses 0x000-0x3FC).
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store word, 0 = load word; sampled with req
- addr  in  32  byte address; sampled with req
- wdata  in  32  store data; sampled with req
- rdata  out  32  load data; valid only while ready=1
- ready  out  1  one-cycle response pulse
- err  out  1  error flag; valid only while ready=1
- busy  out  1  request in flight (state != IDLE)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; ready=0, err=0, busy=0, rdata=0; wait counter=0.
  - Latched addr/we/wdata are cleared.
  - memory contents are NOT reset; they are preloaded by the bench.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge, latch addr, we, wdata.
  - Compute bad = (addr[1:0]!=0) | (addr[31:DEPTH_LOG2+2]!=0).
  - Load counter with LATENCY.
  - Go to WAIT if LATENCY>0, else RESP.
  - req=0: stay in IDLE.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==1, go to RESP.
  - req and all inputs are ignored.
- Transition into RESP, on that same edge:
  - Good store: memory[addr[DEPTH_LOG2+1:2]] <= latched wdata.
  - Good load: rdata <= memory[index]; a store accepted earlier is visible.
  - Bad request: no memory write, rdata <= 0, err <= 1.
- RESP:
  - ready=1 for exactly one cycle; err as computed; busy=1.
  - Next edge goes to IDLE and clears ready and err.
  - req in the RESP cycle is ignored.
  - rdata holds its value until the next response.
- Timing:
  - Acceptance edge k gives ready high in cycle k+1+LATENCY.
  - Minimum request spacing is LATENCY+2 cycles.
- busy=1 in WAIT and RESP, 0 in IDLE. The core must hold req low or repeat it until it sees busy=0.
- Store response: ready=1 with rdata unchanged from its previous value.
- Reset mid-operation: the transaction is dropped. A store still in WAIT never reaches memory. A store already written on the RESP edge stays written.
- Boundaries:
  - Index wraps nowhere; out-of-range addresses are errors, not aliases.
  - Highest legal word, addr=0x3FC at the defaults, must work.
- Widths: index is addr[DEPTH_LOG2+1:2], unsigned. No byte/halfword access.

Test Plan:
- Preload memory[1]=0xDEADBEEF; req, we=0, addr=0x4 at edge 0 (LATENCY=2) -> busy=1 cycles 1-3; ready=1, rdata=0xDEADBEEF, err=0 in cycle 3 only; busy=0 in cycle 4.
- Store wdata=0x12345678 to addr=0x20, then load 0x20 -> second ready returns rdata=0x12345678, and memory[8]=0x12345678 at the first ready.
- Load from addr=0x6 (misaligned), then store to addr=0x400 (out of range) -> each gives ready=1, err=1, rdata=0; memory unchanged; the following good load of 0x400-aliased word 0 returns its preload value.
- LATENCY=0 build: req at edge 0 -> ready in cycle 1. Hold req high continuously -> accepts every 2 cycles, never in the RESP cycle.
- Store to 0x3FC accepted, reset_n pulsed low during WAIT -> outputs zero immediately; after release, memory[255] keeps its old value and state is IDLE.
- Req toggled every cycle during WAIT with differing addr/wdata -> response reflects only the originally accepted request.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : word data memory answering core loads/stores over req/ready
//                  with LATENCY programmable wait states.
// Rev 1.0
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int         c_WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]           memory [0:c_WORDS-1];

  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_we;
  logic                  r_bad;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_bad_in;
  logic                  w_from_idle;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_wdata_sel;
  logic                  w_we_sel;
  logic                  w_bad_sel;
  logic                  w_mem_wr;

  // Out-of-range addresses are errors rather than aliases of low words.
  assign w_bad_in = (addr[1:0] != 2'b00) | (addr[31:DEPTH_LOG2+2] != '0);

  // With zero latency the access happens on the acceptance edge itself,
  // so the live inputs are used instead of the latched copies.
  assign w_from_idle = (r_state == S_IDLE);
  assign w_idx       = w_from_idle ? addr[DEPTH_LOG2+1:2] : r_idx;
  assign w_wdata_sel = w_from_idle ? wdata    : r_wdata;
  assign w_we_sel    = w_from_idle ? we       : r_we;
  assign w_bad_sel   = w_from_idle ? w_bad_in : r_bad;

  assign w_mem_wr = w_enter_resp & w_we_sel & ~w_bad_sel & reset_n;

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept  = 1'b1;
          w_cnt_nxt = c_LAT;
          if (c_LAT == 4'd0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_bad   <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_accept) begin
        r_idx   <= addr[DEPTH_LOG2+1:2];
        r_wdata <= wdata;
        r_we    <= we;
        r_bad   <= w_bad_in;
      end
      ready <= w_enter_resp;
      err   <= w_enter_resp & w_bad_sel;
      // Store responses leave rdata untouched; bad requests zero it.
      if (w_enter_resp) begin
        if (w_bad_sel) begin
          rdata <= 32'd0;
        end else if (!w_we_sel) begin
          rdata <= memory[w_idx];
        end
      end
    end
  end

  // Contents survive reset; only the access strobe is reset-qualified.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      memory[w_idx] <= w_wdata_sel;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : vector-table bench for dmem_responder (LATENCY 2 and 0).
// Rev 1.0
// ============================================================================
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;

  logic        req0, we0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .busy    (busy)
  );

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req0),
    .we      (we0),
    .addr    (addr0),
    .wdata   (wdata0),
    .rdata   (rdata0),
    .ready   (ready0),
    .err     (err0),
    .busy    (busy0)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // One transaction on the LATENCY=2 instance with cycle-exact handshake checks.
  task automatic txn(input int id, input vec_t v);
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c <= LAT) begin
        chk($sformatf("t%0d_c%0d_wait", id, c), 32'({busy, ready}), 32'b10);
      end else if (c == LAT + 1) begin
        chk($sformatf("t%0d_resp_flags", id), 32'({busy, ready, err}), 32'({2'b11, v.exp_err}));
        chk($sformatf("t%0d_rdata", id), rdata, v.exp_rdata);
        if (v.we && !v.exp_err)
          chk($sformatf("t%0d_mem", id), u_dut.memory[v.addr[9:2]], v.wdata);
      end else begin
        chk($sformatf("t%0d_idle", id), 32'({busy, ready}), 32'b00);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,          32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'h1234_5678,  32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,          32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0006, 32'h0,          32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'h1111_1111,  32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0003, 32'h2222_2222,  32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,          32'hA5A5_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_03FC, 32'h0,          32'hCAFE_F00D, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D,  32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_03FC, 32'h0,          32'h0BAD_F00D, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'h0,          32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h0000_1000, 32'h0,          32'h0,         1'b1};

    reset_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    u_dut.memory[0]   = 32'hA5A5_0000;
    u_dut.memory[1]   = 32'hDEAD_BEEF;
    u_dut.memory[8]   = 32'h0;
    u_dut.memory[255] = 32'hCAFE_F00D;
    u_dut0.memory[3]  = 32'h3333_3333;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", 32'({busy, ready, err}), 32'b000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_flags0", 32'({busy0, ready0, err0}), 32'b000);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) txn(i, vecs[i]);

    // Inputs wiggle throughout WAIT and RESP; only the accepted load counts.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h4; wdata = 32'h0;
    @(posedge clk);
    #1 we = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("tog_c1", 32'({busy, ready}), 32'b10);
    req = 1'b0;
    @(negedge clk);
    chk("tog_c2", 32'({busy, ready}), 32'b10);
    req = 1'b1;
    @(negedge clk);
    chk("tog_resp", 32'({busy, ready, err}), 32'b110);
    chk("tog_rdata", rdata, 32'hDEAD_BEEF);
    req = 1'b0;
    @(negedge clk);
    chk("tog_idle", 32'({busy, ready}), 32'b00);
    chk("tog_mem8", u_dut.memory[8], 32'h1234_5678);

    // Reset during WAIT drops a pending store to the top word.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h3FC; wdata = 32'h5555_5555;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("rstw_busy", 32'(busy), 32'b1);
    reset_n = 1'b0;
    #1;
    chk("rstw_flags", 32'({busy, ready, err}), 32'b000);
    chk("rstw_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_mem255", u_dut.memory[255], 32'h0BAD_F00D);
    chk("rstw_idle", 32'(busy), 32'b0);
    v = '{1'b0, 32'h0000_03FC, 32'h0, 32'h0BAD_F00D, 1'b0};
    txn(20, v);

    // Zero-latency instance with req held high: accepts every second edge.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'hC;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin
        chk($sformatf("l0_c%0d_resp", c), 32'({busy0, ready0, err0}), 32'b110);
        chk($sformatf("l0_c%0d_rdata", c), rdata0, 32'h3333_3333);
      end else begin
        chk($sformatf("l0_c%0d_idle", c), 32'({busy0, ready0}), 32'b00);
      end
    end
    req0 = 1'b0;
    @(negedge clk);
    chk("l0_quiet", 32'({busy0, ready0}), 32'b00);

    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h4444_4444;
    @(posedge clk);
    #1 req0 = 1'b0;
    @(negedge clk);
    chk("l0_st_flags", 32'({busy0, ready0, err0}), 32'b110);
    chk("l0_st_rdata", rdata0, 32'h3333_3333);
    chk("l0_st_mem", u_dut0.memory[4], 32'h4444_4444);
    @(negedge clk);
    chk("l0_st_idle", 32'({busy0, ready0}), 32'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
